// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin arbiter issuing single-cycle writes to a shared
// enable register, with a programmable hold window after every write.
module reg_write_arbiter #(
    parameter int WIDTH       = 7,
    parameter int N           = 4,
    parameter int HOLD_CYCLES = 2,
    localparam int IDW        = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       req,
    input  logic [N*WIDTH-1:0] wdata,
    output logic [N-1:0]       gnt,
    output logic               reg_en,
    output logic [WIDTH-1:0]   reg_d,
    output logic               busy,
    output logic [IDW-1:0]     last_id
);
    localparam int CW = HOLD_CYCLES > 0 ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES > 0 ? HOLD_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d, last_id_q, last_id_d, win;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic             reg_en_q, reg_en_d, busy_q, busy_d, found;
    logic [WIDTH-1:0] reg_d_q, reg_d_d;

    // first requester at or after ptr, wrapping at N-1
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[(int'(ptr_q) + k) % N]) begin
                found = 1'b1;
                win   = IDW'((int'(ptr_q) + k) % N);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = '0;
        reg_en_d  = 1'b0;
        reg_d_d   = reg_d_q;
        last_id_d = last_id_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d      = GRANT;
                    gnt_d[win]   = 1'b1;
                    reg_en_d     = 1'b1;
                    reg_d_d      = wdata[int'(win)*WIDTH +: WIDTH];
                    last_id_d    = win;
                    ptr_d        = (win == IDW'(N - 1)) ? '0 : win + 1'b1;
                end
            end
            GRANT: begin
                state_d = HOLD_CYCLES > 0 ? HOLD : IDLE;
                cnt_d   = '0;
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) state_d = IDLE;
                else cnt_d = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            reg_en_q  <= 1'b0;
            reg_d_q   <= '0;
            busy_q    <= 1'b0;
            last_id_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            reg_en_q  <= reg_en_d;
            reg_d_q   <= reg_d_d;
            busy_q    <= busy_d;
            last_id_q <= last_id_d;
        end
    end

    assign gnt     = gnt_q;
    assign reg_en  = reg_en_q;
    assign reg_d   = reg_d_q;
    assign busy    = busy_q;
    assign last_id = last_id_q;
endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin write arbiter that shares one 7-bit synchronous-enable register among N requesters. It drives the register's `en`/`d` inputs, issuing one single-cycle write per grant. Each write is followed by a programmable hold window so downstream logic sees a stable `q` before the next write. It sits directly in front of the shared `register_sync_enable` instance in the datapath.

## Interface
- `WIDTH`, 7, data width of the shared register.
- `N`, 4, number of requesters (≥2); `IDW = $clog2(N)`.
- `HOLD_CYCLES`, 2, idle cycles after each write before the next grant decision (0 allowed).

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  N  per-requester write request, level.
- `wdata`  in  N*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
- `gnt`  out  N  one-hot grant, high for exactly the write cycle.
- `reg_en`  out  1  to shared register `en`.
- `reg_d`  out  WIDTH  to shared register `d`.
- `busy`  out  1  high in GRANT and HOLD.
- `last_id`  out  IDW  index of the most recent winner.

## Operation
- FSM states:
  - **IDLE**: if `req != 0`, pick the winner and go to GRANT; otherwise stay.
  - **GRANT**: lasts 1 cycle; then HOLD if `HOLD_CYCLES > 0`, else IDLE.
  - **HOLD**: counts `HOLD_CYCLES` cycles, then IDLE.
- Arbitration: round-robin pointer `ptr` (IDW bits). The winner is the first i with `req[i]=1`, searching from `ptr` upward and wrapping at N-1 → 0.
  - On a grant, `ptr` ← winner+1 (mod N); `last_id` ← winner.
- All outputs are registered. On the IDLE→GRANT edge:
  - `gnt` ← onehot(winner), `reg_en` ← 1, `reg_d` ← winner's `wdata` slice.
  - `wdata` is sampled only on that edge.
- Leaving GRANT: `gnt` ← 0, `reg_en` ← 0. `reg_d` holds its last value.
- Requests seen in GRANT/HOLD are not evaluated. A requester still asserting `req` at the return to IDLE competes again as a new request.
- A requester is expected to drop `req` the cycle after seeing its `gnt`. Failing to do so causes a repeat write, which is legal.
- `req` dropped before a decision edge is simply not considered; there is no request latching.
- HOLD counter width is `$clog2(HOLD_CYCLES+1)`. It loads 0 on entering HOLD and exits when it reaches `HOLD_CYCLES-1`.
- Reset (`reset=0`, asynchronous):
  - state IDLE, `ptr=0`, `gnt=0`, `reg_en=0`, `reg_d=0`, `busy=0`, `last_id=0`, counter 0.
  - Asserted mid-GRANT: `reg_en` drops immediately and that write is aborted. No pending state survives.
- Deassertion of `reset` is assumed synchronous to `clk` by the integrator. The first decision happens at the first rising edge with `reset=1`.

## Timing
- Request high before edge k (in IDLE) → `gnt`/`reg_en`/`reg_d` valid after edge k. The shared register captures at edge k+1, so `q` is updated after edge k+1 (write latency 2 edges).
- `busy` is high from after edge k until after edge k+1+HOLD_CYCLES.
- Minimum spacing between successive `reg_en` pulses is `HOLD_CYCLES+2` cycles (4 with defaults, 2 with HOLD_CYCLES=0).
- `reg_en` is never high for two consecutive cycles.
- At most one bit of `gnt` is ever set.
- `gnt` is high only while `reg_en` is high.

## Test plan
- **Single request**: after reset, `req=4'b0010`, `wdata[13:7]=7'b1010101`, held for one cycle. Required: `gnt=4'b0010` and `reg_en=1` for exactly one cycle; `reg_d=7'b1010101`; `last_id=1`; shared `q=7'b1010101` one cycle later; `busy` high for 3 cycles.
- **Round-robin fairness**: `req=4'b1111` held constant, distinct data per requester. Required: winners 0,1,2,3,0 in order, `reg_en` pulses exactly 4 cycles apart, `reg_d` matching each winner's slice.
- **Wrap-around and skip**: `ptr=3` (after a grant to 2), then `req=4'b0101`. Required: grant to 0, then 2; requester 3 is skipped without a wasted cycle.
- **Requests during HOLD**: raise `req[2]` one cycle after a grant to 1 and drop it before HOLD ends. Required: no grant to 2, `reg_en` stays 0, and `q` holds the written value.
- **Reset mid-GRANT**: assert `reset=0` three ns after the grant edge. Required: `reg_en`, `gnt` and `busy` go to 0 immediately; `q` is unchanged; after release with `req=4'b1000` the grant goes to 3 (`ptr=0` search).
- **HOLD_CYCLES=0 build**: `req=4'b0011` held constant. Required: `reg_en` pulses every 2 cycles, alternating grants 0,1,0,1.
